// File: rtl/picorv32_worker_bridge_if.sv
// -----------------------------------------------------------------------------
// picorv32_worker_bridge_if
//
// Bundles the two buses that meet at the bridge:
//   * the PicoRV32 native memory port (mem_*), and
//   * the worker memory handshake (w_wr_*, w_rd_*).
//
// Modports:
//   master : the bridge. It consumes CPU requests and issues worker
//            transactions.
//   slave  : the environment around the bridge. This is the CPU driving
//            mem_* requests and the worker answering w_* transactions.
//
// Handshake semantics, used by both the CPU and the worker side:
//   A transfer happens on a rising edge where valid && ready are both high.
//   Once valid is raised, its address, data and byte enables are held stable
//   until that transfer edge. mem_ready is a single-cycle completion pulse
//   that needs no valid from the bridge side. w_rd_data is only meaningful
//   while w_rd_ready is high.
//
// N_ADDR_BITS must match the bridge and the worker it feeds.
// -----------------------------------------------------------------------------
interface picorv32_worker_bridge_if #(
   parameter int unsigned N_ADDR_BITS = 8
);
   // CPU native memory port
   logic                   mem_valid;
   logic                   mem_instr;
   logic [31:0]            mem_addr;
   logic [31:0]            mem_wdata;
   logic [3:0]             mem_wstrb;
   logic                   mem_ready;
   logic [31:0]            mem_rdata;

   // worker write channel
   logic                   w_wr_valid;
   logic                   w_wr_ready;
   logic [N_ADDR_BITS-1:0] w_wr_addr;
   logic [31:0]            w_wr_data;
   logic [3:0]             w_wr_byteEn;

   // worker read channel
   logic                   w_rd_valid;
   logic                   w_rd_ready;
   logic [N_ADDR_BITS-1:0] w_rd_addr;
   logic [31:0]            w_rd_data;

   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output w_wr_valid, w_wr_addr, w_wr_data, w_wr_byteEn,
      input  w_wr_ready,
      output w_rd_valid, w_rd_addr,
      input  w_rd_ready, w_rd_data
   );

   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  w_wr_valid, w_wr_addr, w_wr_data, w_wr_byteEn,
      output w_wr_ready,
      input  w_rd_valid, w_rd_addr,
      output w_rd_ready, w_rd_data
   );
endinterface

// File: rtl/picorv32_worker_bridge.sv
// -----------------------------------------------------------------------------
// picorv32_worker_bridge
//
// Converts each PicoRV32 native memory request into exactly one worker write
// or read transaction and returns a one-cycle mem_ready to the CPU.
//
// The bridge rejects a request without touching the worker when its address
// is outside the worker window or is not word aligned. It also abandons a
// worker transaction that stays unanswered for TIMEOUT_CYCLES cycles. Both
// error cases complete with mem_rdata = ERR_DATA and set a sticky err flag.
// err_addr holds the address of the first error since the last clear.
//
// Ports:
//   clock, reset : single rising-edge clock, synchronous active-high reset.
//   bus          : CPU mem_* port and worker w_* port (master modport).
//   err          : sticky error flag.
//   err_addr     : CPU address of the first error since the last clear.
//   err_clear    : clears err and err_addr. A new error in the same cycle
//                  takes priority over the clear.
//   dbg_state    : current FSM state (0 IDLE, 1 WR, 2 RD, 3 ACK).
//
// Every output is a flop, and every flop resets to zero.
// -----------------------------------------------------------------------------
module picorv32_worker_bridge #(
   parameter int unsigned N_ADDR_BITS    = 8,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                            clock,
   input  logic                            reset,
   picorv32_worker_bridge_if.master        bus,
   output logic                            err,
   output logic [31:0]                     err_addr,
   input  logic                            err_clear,
   output logic [1:0]                      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   // The counter only ever has to reach TIMEOUT_CYCLES-1.
   localparam int unsigned TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [TW-1:0]          cnt_q, cnt_d;
   logic                   ready_q, ready_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [N_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]            wr_data_q, wr_data_d;
   logic [3:0]             wr_be_q, wr_be_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [N_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic                   err_q, err_d;
   logic [31:0]            err_addr_q, err_addr_d;

   logic                   in_window;
   logic                   aligned;
   logic                   timeout_hit;
   logic                   fault;
   logic [31:0]            fault_addr;

   // Instruction fetches and data accesses are handled the same way.
   logic                   unused_instr;
   assign unused_instr = bus.mem_instr;

   assign in_window   = (bus.mem_addr[31:N_ADDR_BITS] == BASE_ADDR[31:N_ADDR_BITS]);
   assign aligned     = (bus.mem_addr[1:0] == 2'b00);
   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = 1'b0;
      rdata_d    = rdata_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_be_d    = wr_be_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      fault      = 1'b0;
      fault_addr = 32'h0;

      if (err_clear) begin
         err_d      = 1'b0;
         err_addr_d = 32'h0;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.mem_valid) begin
               cnt_d = '0;
               if (!in_window || !aligned) begin
                  fault      = 1'b1;
                  fault_addr = bus.mem_addr;
                  ready_d    = 1'b1;
                  rdata_d    = ERR_DATA;
                  state_d    = S_ACK;
               end else if (bus.mem_wstrb != 4'b0000) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = bus.mem_addr[N_ADDR_BITS-1:0];
                  wr_data_d  = bus.mem_wdata;
                  wr_be_d    = bus.mem_wstrb;
                  state_d    = S_WR;
               end else begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = bus.mem_addr[N_ADDR_BITS-1:0];
                  state_d    = S_RD;
               end
            end
         end

         // A low w_wr_ready at entry means the worker is still recovering
         // from the previous write. The bridge simply keeps waiting.
         S_WR: begin
            if (wr_valid_q && bus.w_wr_ready) begin
               wr_valid_d = 1'b0;
               ready_d    = 1'b1;
               state_d    = S_ACK;
            end else if (timeout_hit) begin
               wr_valid_d = 1'b0;
               fault      = 1'b1;
               fault_addr = {BASE_ADDR[31:N_ADDR_BITS], wr_addr_q};
               ready_d    = 1'b1;
               rdata_d    = ERR_DATA;
               state_d    = S_ACK;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         // w_rd_valid drops on the same edge that captures the data, which
         // is also the edge on which the pipelined worker drops w_rd_ready.
         S_RD: begin
            if (rd_valid_q && bus.w_rd_ready) begin
               rd_valid_d = 1'b0;
               rdata_d    = bus.w_rd_data;
               ready_d    = 1'b1;
               state_d    = S_ACK;
            end else if (timeout_hit) begin
               rd_valid_d = 1'b0;
               fault      = 1'b1;
               fault_addr = {BASE_ADDR[31:N_ADDR_BITS], rd_addr_q};
               ready_d    = 1'b1;
               rdata_d    = ERR_DATA;
               state_d    = S_ACK;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         // mem_ready is high in this cycle. mem_valid is deliberately ignored
         // here, because the CPU still holds it until it has seen ready.
         S_ACK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new error outranks a same-cycle clear. Only the first error
      // address is kept while err stays set.
      if (fault) begin
         err_d = 1'b1;
         if (!err_q || err_clear) begin
            err_addr_d = fault_addr;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 32'h0;
         wr_be_q    <= 4'h0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_be_q    <= wr_be_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.mem_ready   = ready_q;
   assign bus.mem_rdata   = rdata_q;
   assign bus.w_wr_valid  = wr_valid_q;
   assign bus.w_wr_addr   = wr_addr_q;
   assign bus.w_wr_data   = wr_data_q;
   assign bus.w_wr_byteEn = wr_be_q;
   assign bus.w_rd_valid  = rd_valid_q;
   assign bus.w_rd_addr   = rd_addr_q;
   assign err             = err_q;
   assign err_addr        = err_addr_q;
   assign dbg_state       = state_q;

endmodule
